// File: rtl/bp_nonsynth_commit_tracker_pkg.sv
// Shared constants and helpers for the commit/writeback reconciler.
//   cause_width_gp / mstatus_width_gp : widths of the trap cause and mstatus snapshot
//   rd_width_gp                       : destination register index width (instr[11:7])
//   commit_entry_width()              : packed width of one queued commit record
package bp_nonsynth_commit_tracker_pkg;

  localparam int cause_width_gp   = 64;
  localparam int mstatus_width_gp = 64;
  localparam int rd_width_gp      = 5;

  // debug + instret + trap + pc + instr + rf_w + req + cause + mstatus
  function automatic int commit_entry_width(input int vaddr_w, input int instr_w, input int num_rf);
    return 3 + vaddr_w + instr_w + num_rf + 1 + cause_width_gp + mstatus_width_gp;
  endfunction

endpackage

// File: rtl/bp_nonsynth_commit_tracker_wb_bank.sv
// bp_nonsynth_wb_bank: writeback storage for one register file.
// One small FIFO per architectural register, so several writebacks to the same rd
// (before their commits arrive) are consumed strictly in arrival order.
//   clk_i, reset_i  clock, sync active-high reset (empties every FIFO)
//   wb_v_i/addr/data  push wb_data_i into FIFO[wb_addr_i]
//   rd_addr_i       register whose FIFO head is presented
//   pop_i           pop FIFO[rd_addr_i] (caller guarantees non-empty)
//   rd_v_o/data_o   FIFO[rd_addr_i] non-empty / its head
//   drop_o          pulse: push hit a full FIFO and was discarded
module bp_nonsynth_wb_bank
  import bp_nonsynth_commit_tracker_pkg::*;
#(
  parameter int reg_els_p    = 32,
  parameter int lg_wb_els_p  = 3,
  parameter int data_width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    wb_v_i,
  input  logic [rd_width_gp-1:0]  wb_addr_i,
  input  logic [data_width_p-1:0] wb_data_i,
  input  logic [rd_width_gp-1:0]  rd_addr_i,
  input  logic                    pop_i,
  output logic                    rd_v_o,
  output logic [data_width_p-1:0] rd_data_o,
  output logic                    drop_o
);

  localparam int lg_reg_els_lp = (reg_els_p > 1) ? $clog2(reg_els_p) : 1;
  localparam int wb_els_lp     = 1 << lg_wb_els_p;

  logic [data_width_p-1:0] r_mem  [reg_els_p][wb_els_lp];
  logic [lg_wb_els_p:0]    r_wptr [reg_els_p];
  logic [lg_wb_els_p:0]    r_rptr [reg_els_p];

  logic [lg_reg_els_lp-1:0] w_wa, w_ra;
  logic [lg_wb_els_p:0]     w_wfill;
  logic                     w_push;

  assign w_wa    = wb_addr_i[lg_reg_els_lp-1:0];
  assign w_ra    = rd_addr_i[lg_reg_els_lp-1:0];
  // Fill level taken before this cycle's pop: a full FIFO drops even if it is popped now.
  assign w_wfill = r_wptr[w_wa] - r_rptr[w_wa];
  assign w_push  = wb_v_i & (w_wfill != (lg_wb_els_p+1)'(wb_els_lp));
  assign drop_o  = wb_v_i & ~w_push;

  assign rd_v_o    = (r_wptr[w_ra] != r_rptr[w_ra]);
  assign rd_data_o = r_mem[w_ra][r_rptr[w_ra][lg_wb_els_p-1:0]];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[w_wa][r_wptr[w_wa][lg_wb_els_p-1:0]] <= wb_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < reg_els_p; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      if (w_push) r_wptr[w_wa] <= r_wptr[w_wa] + 1'b1;
      if (pop_i)  r_rptr[w_ra] <= r_rptr[w_ra] + 1'b1;
    end
  end

endmodule

// File: rtl/bp_nonsynth_commit_tracker.sv
// bp_nonsynth_commit_tracker: queues in-order commit records, matches them with
// out-of-order writebacks from num_rf_p register files, holds retirement while blocking
// cache requests are outstanding, and emits one resolved record per valid/yumi handshake.
//   clk_i, reset_i          clock, sync active-high reset
//   commit_*_i              commit record (no backpressure; dropped when queue full)
//   wb_v/addr/data_i        per-RF writeback channels
//   req_v_i/req_complete_i  blocking request accept / completion
//   instr_cap_i             finish after this many non-debug retires (0 = never)
//   retire_v_o/yumi_i       retire handshake; retire_pkt_o/retire_data_o the record
//   instr_cnt_o             retired non-debug instruction count
//   finish_o/overrun_o/wb_overflow_o/timeout_o  sticky status flags
module bp_nonsynth_commit_tracker
  import bp_nonsynth_commit_tracker_pkg::*;
#(
  parameter int vaddr_width_p   = 39,
  parameter int instr_width_p   = 32,
  parameter int data_width_p    = 64,
  parameter int num_rf_p        = 2,
  parameter int reg_els_p       = 32,
  parameter int lg_commit_els_p = 4,
  parameter int lg_wb_els_p     = 3,
  parameter int max_req_p       = 128,
  parameter int timeout_p       = 4096,
  localparam int entry_width_lp = commit_entry_width(vaddr_width_p, instr_width_p, num_rf_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               commit_v_i,
  input  logic                               commit_debug_i,
  input  logic                               commit_instret_i,
  input  logic                               commit_trap_i,
  input  logic [vaddr_width_p-1:0]           commit_pc_i,
  input  logic [instr_width_p-1:0]           commit_instr_i,
  input  logic [num_rf_p-1:0]                commit_rf_w_i,
  input  logic                               commit_req_i,
  input  logic [cause_width_gp-1:0]          commit_cause_i,
  input  logic [mstatus_width_gp-1:0]        commit_mstatus_i,
  input  logic [num_rf_p-1:0]                wb_v_i,
  input  logic [num_rf_p*rd_width_gp-1:0]    wb_addr_i,
  input  logic [num_rf_p*data_width_p-1:0]   wb_data_i,
  input  logic                               req_v_i,
  input  logic                               req_complete_i,
  input  logic [31:0]                        instr_cap_i,
  output logic                               retire_v_o,
  input  logic                               retire_yumi_i,
  output logic [entry_width_lp-1:0]          retire_pkt_o,
  output logic [data_width_p-1:0]            retire_data_o,
  output logic [31:0]                        instr_cnt_o,
  output logic                               finish_o,
  output logic                               overrun_o,
  output logic                               wb_overflow_o,
  output logic                               timeout_o
);

  typedef struct packed {
    logic                        debug;
    logic                        instret;
    logic                        trap;
    logic [vaddr_width_p-1:0]    pc;
    logic [instr_width_p-1:0]    instr;
    logic [num_rf_p-1:0]         rf_w;
    logic                        req;
    logic [cause_width_gp-1:0]   cause;
    logic [mstatus_width_gp-1:0] mstatus;
  } bp_nonsynth_commit_entry_s;

  localparam int cq_els_lp     = 1 << lg_commit_els_p;
  localparam int req_cnt_w_lp  = $clog2(max_req_p + 1);
  localparam logic [31:0] timeout_cnt_lp = 32'(timeout_p);

  // ---------------- commit queue ----------------
  bp_nonsynth_commit_entry_s r_cq_mem [cq_els_lp];
  logic [lg_commit_els_p:0]  r_cq_wptr, r_cq_rptr;
  bp_nonsynth_commit_entry_s w_enq, w_head;
  logic w_cq_full, w_head_v, w_enq_v;

  assign w_head_v  = (r_cq_wptr != r_cq_rptr);
  assign w_cq_full = (r_cq_wptr[lg_commit_els_p] != r_cq_rptr[lg_commit_els_p])
                   & (r_cq_wptr[lg_commit_els_p-1:0] == r_cq_rptr[lg_commit_els_p-1:0]);
  assign w_enq_v   = commit_v_i & ~w_cq_full;
  assign w_head    = r_cq_mem[r_cq_rptr[lg_commit_els_p-1:0]];

  // A trapping instruction neither writes an RF nor waits on its cache request.
  always_comb begin
    w_enq         = '0;
    w_enq.debug   = commit_debug_i;
    w_enq.instret = commit_instret_i;
    w_enq.trap    = commit_trap_i;
    w_enq.pc      = commit_pc_i;
    w_enq.instr   = commit_instr_i;
    w_enq.rf_w    = commit_trap_i ? '0 : commit_rf_w_i;
    w_enq.req     = commit_req_i & ~commit_trap_i;
    w_enq.cause   = commit_cause_i;
    w_enq.mstatus = commit_mstatus_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_enq_v) r_cq_mem[r_cq_wptr[lg_commit_els_p-1:0]] <= w_enq;
  end

  // ---------------- writeback banks ----------------
  logic [num_rf_p-1:0]                   w_bank_v, w_bank_drop, w_pop;
  logic [num_rf_p-1:0][data_width_p-1:0] w_bank_data;
  logic [rd_width_gp-1:0]                w_rd;

  assign w_rd = w_head.instr[11:7];

  for (genvar r = 0; r < num_rf_p; r++) begin : g_rf
    bp_nonsynth_wb_bank #(
      .reg_els_p   (reg_els_p),
      .lg_wb_els_p (lg_wb_els_p),
      .data_width_p(data_width_p)
    ) u_bank (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .wb_v_i   (wb_v_i[r]),
      .wb_addr_i(wb_addr_i[r*rd_width_gp +: rd_width_gp]),
      .wb_data_i(wb_data_i[r*data_width_p +: data_width_p]),
      .rd_addr_i(w_rd),
      .pop_i    (w_pop[r]),
      .rd_v_o   (w_bank_v[r]),
      .rd_data_o(w_bank_data[r]),
      .drop_o   (w_bank_drop[r])
    );
  end

  // ---------------- retire ----------------
  logic [req_cnt_w_lp-1:0] r_req_cnt;
  logic [31:0]             r_instr_cnt, r_wd_cnt;
  logic                    r_finish, r_overrun, r_wb_overflow, r_timeout;
  logic                    w_ready, w_yumi;
  logic [data_width_p-1:0] w_data;

  assign w_ready = w_head_v
                 & (&(~w_head.rf_w | w_bank_v))
                 & (~w_head.req | (r_req_cnt == '0));
  assign w_yumi  = retire_yumi_i & w_ready;
  assign w_pop   = {num_rf_p{w_yumi}} & w_head.rf_w;

  // rf_w is onehot0, so OR-ing the selected heads yields the single matched value.
  always_comb begin
    w_data = '0;
    for (int r = 0; r < num_rf_p; r++)
      if (w_head.rf_w[r] & w_bank_v[r]) w_data = w_data | w_bank_data[r];
  end

  assign retire_v_o    = w_ready;
  assign retire_pkt_o  = w_head_v ? w_head : '0;
  assign retire_data_o = w_head_v ? w_data : '0;
  assign instr_cnt_o   = r_instr_cnt;
  assign finish_o      = r_finish;
  assign overrun_o     = r_overrun;
  assign wb_overflow_o = r_wb_overflow;
  assign timeout_o     = r_timeout;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cq_wptr     <= '0;
      r_cq_rptr     <= '0;
      r_req_cnt     <= '0;
      r_instr_cnt   <= '0;
      r_wd_cnt      <= '0;
      r_finish      <= 1'b0;
      r_overrun     <= 1'b0;
      r_wb_overflow <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_enq_v) r_cq_wptr <= r_cq_wptr + 1'b1;
      if (w_yumi)  r_cq_rptr <= r_cq_rptr + 1'b1;

      if (req_v_i & ~req_complete_i)      r_req_cnt <= r_req_cnt + 1'b1;
      else if (~req_v_i & req_complete_i) r_req_cnt <= r_req_cnt - 1'b1;

      if (w_yumi & w_head.instret & ~w_head.debug) r_instr_cnt <= r_instr_cnt + 32'd1;
      if ((instr_cap_i != '0) && (r_instr_cnt == instr_cap_i)) r_finish <= 1'b1;

      if (commit_v_i & w_cq_full) r_overrun     <= 1'b1;
      if (|w_bank_drop)           r_wb_overflow <= 1'b1;

      // Only a head that cannot retire ages; a ready head waiting on the consumer holds.
      if (~w_head_v | w_yumi) r_wd_cnt <= '0;
      else if (~w_ready) begin
        if (r_wd_cnt != timeout_cnt_lp) r_wd_cnt <= r_wd_cnt + 32'd1;
        if ((timeout_p != 0) && (r_wd_cnt == timeout_cnt_lp - 32'd1)) r_timeout <= 1'b1;
      end
    end
  end

  a_rf_w_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
    commit_v_i |-> $onehot0(commit_rf_w_i));
  a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    retire_yumi_i |-> retire_v_o);
  a_req_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(req_v_i && !req_complete_i && (r_req_cnt == req_cnt_w_lp'(max_req_p))));
  a_req_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(req_complete_i && !req_v_i && (r_req_cnt == '0)));

endmodule
